// File: rtl/hs_cdc_tx_arbiter.sv
// Round-robin arbiter feeding one registered valid/ready channel into a CDC crossing.
// The channel state is carried entirely by ch_valid (IDLE = 0, SEND = 1).
module hs_cdc_tx_arbiter #(
  parameter type      DATA_TYPE   = logic,
  parameter DATA_TYPE RESET_VALUE = '0,
  parameter int       NUM_REQ     = 4,
  parameter int       ID_W        = $clog2(NUM_REQ),
  parameter int       CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  DATA_TYPE             req_data [NUM_REQ],
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 ch_valid,
  output DATA_TYPE             ch_data,
  output logic [ID_W-1:0]      ch_id,
  input  logic                 ch_ready,
  output logic                 busy,
  output logic [CNT_W-1:0]     xfer_cnt
);

  typedef logic [ID_W:0] wide_t;

  logic [ID_W-1:0] ptr_r;
  logic [ID_W-1:0] sel_s;
  logic [ID_W-1:0] nxt_ptr_s;
  wide_t           sel_p1_s;
  logic            load_s;
  logic            any_s;

  assign load_s = !ch_valid || ch_ready;
  assign any_s  = |req_valid;
  assign busy   = ch_valid;

  // Winner search: walk downward so the last hit is the first valid index at or after ptr_r.
  always_comb begin
    wide_t sum_v;
    wide_t idx_v;
    sel_s = ptr_r;
    sum_v = '0;
    idx_v = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum_v = {1'b0, ptr_r} + wide_t'(k);
      idx_v = (sum_v >= wide_t'(NUM_REQ)) ? (sum_v - wide_t'(NUM_REQ)) : sum_v;
      sel_s = req_valid[idx_v[ID_W-1:0]] ? idx_v[ID_W-1:0] : sel_s;
    end
  end

  // Pointer advance wraps at NUM_REQ so non-power-of-2 sizes never see an out-of-range ptr.
  always_comb begin
    sel_p1_s  = {1'b0, sel_s} + wide_t'(1);
    nxt_ptr_s = (sel_p1_s == wide_t'(NUM_REQ)) ? '0 : sel_p1_s[ID_W-1:0];
  end

  // Accept strobe; forced low while reset is asserted.
  always_comb begin
    if (aresetn && load_s && any_s) begin
      req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_s;
    end else begin
      req_ready = '0;
    end
  end

  // Channel register and round-robin pointer.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      ch_valid <= 1'b0;
      ch_data  <= RESET_VALUE;
      ch_id    <= '0;
      ptr_r    <= '0;
    end else if (load_s) begin
      if (any_s) begin
        ch_valid <= 1'b1;
        ch_data  <= req_data[sel_s];
        ch_id    <= sel_s;
        ptr_r    <= nxt_ptr_s;
      end else begin
        ch_valid <= 1'b0;
      end
    end
  end

  // Completed-handshake counter; ch_ready while idle does not count.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      xfer_cnt <= '0;
    end else if (ch_valid && ch_ready) begin
      xfer_cnt <= xfer_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_hs_cdc_tx_arbiter.sv
// Bench for hs_cdc_tx_arbiter: directed vector table, multi-cycle corner cases on a 4- and a
// 3-requester instance, then randomized traffic against a behavioural model.
module tb_hs_cdc_tx_arbiter;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  // 4-requester instance, 16-bit counter
  logic [3:0]  v4 = 4'h0;
  logic [7:0]  d4 [4];
  logic [3:0]  rr4;
  logic        cv4, rdy4 = 1'b0, busy4;
  logic [7:0]  cd4;
  logic [1:0]  id4;
  logic [15:0] cnt4;

  // 3-requester instance, 4-bit counter
  logic [2:0]  v3 = 3'h0;
  logic [7:0]  d3 [3];
  logic [2:0]  rr3;
  logic        cv3, rdy3 = 1'b0, busy3;
  logic [7:0]  cd3;
  logic [1:0]  id3;
  logic [3:0]  cnt3;

  hs_cdc_tx_arbiter #(.DATA_TYPE(logic [7:0]), .NUM_REQ(4), .CNT_W(16)) dut4 (
    .clk(clk), .aresetn(aresetn), .req_valid(v4), .req_data(d4), .req_ready(rr4),
    .ch_valid(cv4), .ch_data(cd4), .ch_id(id4), .ch_ready(rdy4), .busy(busy4), .xfer_cnt(cnt4));

  hs_cdc_tx_arbiter #(.DATA_TYPE(logic [7:0]), .NUM_REQ(3), .CNT_W(4)) dut3 (
    .clk(clk), .aresetn(aresetn), .req_valid(v3), .req_data(d3), .req_ready(rr3),
    .ch_valid(cv3), .ch_data(cd3), .ch_id(id3), .ch_ready(rdy3), .busy(busy3), .xfer_cnt(cnt3));

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  typedef struct {
    logic [3:0]  v;
    logic        rdy;
    logic [3:0]  rr;
    logic        cv;
    logic [1:0]  id;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input logic [3:0] v, input logic rdy, input logic [3:0] rr,
                         input logic cv, input logic [1:0] id, input logic [15:0] cnt);
    vec_t t;
    t.v = v; t.rdy = rdy; t.rr = rr; t.cv = cv; t.id = id; t.cnt = cnt;
    tbl.push_back(t);
  endtask

  // behavioural model state for the randomized phase
  bit         m_cv;
  int         m_ptr, m_id, m_cnt, sel;
  logic [7:0] m_data;
  logic [3:0] exp_rr, acc;
  bit         load;

  initial begin
    for (int i = 0; i < 4; i++) d4[i] = 8'hA0 + 8'(i);
    for (int i = 0; i < 3; i++) d3[i] = 8'hB0 + 8'(i);

    // rotation, drop, single-word then backpressure, release order 3 then 0, lone requester 2
    for (int j = 0; j < 6; j++) add_vec(4'hF, 1'b1, 4'b0001 << (j % 4), 1'b1, 2'(j % 4), 16'(j));
    add_vec(4'h0, 1'b1, 4'h0, 1'b0, 2'd1, 16'd6);
    add_vec(4'h2, 1'b0, 4'h2, 1'b1, 2'd1, 16'd6);
    for (int j = 0; j < 5; j++) add_vec(4'h9, 1'b0, 4'h0, 1'b1, 2'd1, 16'd6);
    add_vec(4'h9, 1'b1, 4'h8, 1'b1, 2'd3, 16'd7);
    add_vec(4'h1, 1'b1, 4'h1, 1'b1, 2'd0, 16'd8);
    add_vec(4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 16'd9);
    add_vec(4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 16'd9);
    for (int j = 0; j < 3; j++) add_vec(4'h4, 1'b1, 4'h4, 1'b1, 2'd2, 16'(9 + j));
    add_vec(4'h0, 1'b1, 4'h0, 1'b0, 2'd2, 16'd12);

    // reset: req_ready must stay low even with requests pending
    v4 = 4'hF;
    #1;
    chk("rst_req_ready", 32'(rr4), 32'h0);
    chk("rst_ch_valid", 32'(cv4), 32'h0);
    chk("rst_ch_id", 32'(id4), 32'h0);
    chk("rst_busy", 32'(busy4), 32'h0);
    v4 = 4'h0;
    @(negedge clk);
    @(negedge clk);
    aresetn = 1'b1;

    // idle 10 cycles, ready toggling while idle must not count
    for (int j = 0; j < 10; j++) begin
      rdy4 = 1'(j % 2);
      @(negedge clk);
    end
    chk("idle_ch_valid", 32'(cv4), 32'h0);
    chk("idle_ch_data", 32'(cd4), 32'h0);
    chk("idle_xfer_cnt", 32'(cnt4), 32'h0);
    chk("idle_req_ready", 32'(rr4), 32'h0);

    foreach (tbl[n]) begin
      v4 = tbl[n].v;
      rdy4 = tbl[n].rdy;
      #1;
      chk($sformatf("vec%0d_req_ready", n), 32'(rr4), 32'(tbl[n].rr));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_ch_valid", n), 32'(cv4), 32'(tbl[n].cv));
      chk($sformatf("vec%0d_ch_id", n), 32'(id4), 32'(tbl[n].id));
      chk($sformatf("vec%0d_ch_data", n), 32'(cd4), 32'(8'hA0 + 8'(tbl[n].id)));
      chk($sformatf("vec%0d_xfer_cnt", n), 32'(cnt4), 32'(tbl[n].cnt));
      @(negedge clk);
    end

    // reset while a word is stalled on the channel (ptr is 3 here, so 0 wins)
    v4 = 4'h1;
    rdy4 = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_load_valid", 32'(cv4), 32'h1);
    chk("mid_load_id", 32'(id4), 32'h0);
    @(negedge clk);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_ch_valid", 32'(cv4), 32'h0);
    chk("mid_rst_req_ready", 32'(rr4), 32'h0);
    chk("mid_rst_ch_data", 32'(cd4), 32'h0);
    chk("mid_rst_xfer_cnt", 32'(cnt4), 32'h0);
    @(negedge clk);
    aresetn = 1'b1;
    v4 = 4'hA;
    rdy4 = 1'b1;
    #1;
    chk("post_rst_req_ready", 32'(rr4), 32'h2);
    @(posedge clk);
    #1;
    chk("post_rst_ch_id", 32'(id4), 32'h1);
    chk("post_rst_ch_data", 32'(cd4), 32'hA1);
    @(negedge clk);
    v4 = 4'h0;
    @(negedge clk);

    // 3 requesters: rotation 0,1,2,... ; 17 words on a 4-bit counter wraps to 1
    v3 = 3'h7;
    rdy3 = 1'b1;
    for (int j = 0; j < 17; j++) begin
      @(posedge clk);
      #1;
      chk($sformatf("n3_word%0d_ch_id", j), 32'(id3), 32'(j % 3));
      chk($sformatf("n3_word%0d_ch_data", j), 32'(cd3), 32'(8'hB0 + 8'(j % 3)));
      chk($sformatf("n3_word%0d_ptr_range", j), 32'(dut3.ptr_r < 2'd3), 32'h1);
    end
    @(negedge clk);
    v3 = 3'h0;
    @(posedge clk);
    #1;
    chk("n3_xfer_cnt_wrap", 32'(cnt3), 32'h1);
    chk("n3_idle", 32'(cv3), 32'h0);
    @(negedge clk);

    // randomized traffic on the 4-requester instance from a fresh reset
    aresetn = 1'b0;
    @(negedge clk);
    aresetn = 1'b1;
    m_cv = 0; m_ptr = 0; m_id = 0; m_cnt = 0; m_data = 8'h00;
    acc = 4'hF;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) if (acc[i]) d4[i] = 8'($urandom);
      v4 = 4'($urandom);
      rdy4 = ($urandom_range(0, 3) != 0);
      load = !m_cv || rdy4;
      sel = -1;
      for (int k = 0; k < 4; k++) begin
        if (sel < 0 && v4[(m_ptr + k) % 4]) sel = (m_ptr + k) % 4;
      end
      exp_rr = (load && sel >= 0) ? (4'b0001 << sel) : 4'h0;
      #1;
      chk($sformatf("rnd%0d_req_ready", c), 32'(rr4), 32'(exp_rr));
      if (m_cv && rdy4) m_cnt = (m_cnt + 1) % 65536;
      if (load) begin
        if (sel >= 0) begin
          m_cv = 1; m_data = d4[sel]; m_id = sel; m_ptr = (sel + 1) % 4;
        end else begin
          m_cv = 0;
        end
      end
      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d_ch_valid", c), 32'(cv4), 32'(m_cv));
      chk($sformatf("rnd%0d_busy", c), 32'(busy4), 32'(m_cv));
      chk($sformatf("rnd%0d_ch_id", c), 32'(id4), 32'(m_id));
      chk($sformatf("rnd%0d_ch_data", c), 32'(cd4), 32'(m_data));
      chk($sformatf("rnd%0d_xfer_cnt", c), 32'(cnt4), 32'(m_cnt));
      @(negedge clk);
      acc = exp_rr;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
